// File: rtl/layer_sequencer.sv
// Inter-layer sequencer: gathers one frame of parallel neuron activations,
// then streams the words in lane order to the next layer's serial input.
module layer_sequencer #(
  parameter int NUM_NEURON = 10,
  parameter int NUM_NEXT   = 10,
  parameter int DATA_WIDTH = 16
) (
  input  logic                             i_clk,
  input  logic                             i_reset,
  input  logic [NUM_NEURON*DATA_WIDTH-1:0] i_data,
  input  logic [NUM_NEURON-1:0]            i_data_valid,
  input  logic [NUM_NEXT-1:0]              i_next_ready,
  output logic [DATA_WIDTH-1:0]            o_data,
  output logic                             o_data_valid,
  output logic                             o_busy,
  output logic                             o_frame_done,
  output logic                             o_overflow
);

  localparam int IDX_W = (NUM_NEURON > 1) ? $clog2(NUM_NEURON) : 1;

  typedef enum logic {COLLECT, STREAM} state_t;

  state_t                  state, state_next;
  logic [DATA_WIDTH-1:0]   buffer [NUM_NEURON];
  logic [NUM_NEURON-1:0]   mask;
  logic [IDX_W-1:0]        index;
  logic                    ready_all;
  logic                    frame_full;
  logic                    last_word;

  assign ready_all  = &i_next_ready;
  assign frame_full = &(mask | i_data_valid);
  assign last_word  = (index == IDX_W'(NUM_NEURON - 1));
  assign o_busy     = (state == STREAM);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state <= COLLECT;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      COLLECT: if (frame_full) state_next = STREAM;
      STREAM:  if (ready_all && last_word) state_next = COLLECT;
      default: state_next = COLLECT;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      mask         <= '0;
      index        <= '0;
      o_data       <= '0;
      o_data_valid <= 1'b0;
      o_frame_done <= 1'b0;
      o_overflow   <= 1'b0;
      for (int unsigned n = 0; n < NUM_NEURON; n++) begin
        buffer[n] <= '0;
      end
    end else begin
      o_data_valid <= 1'b0;
      o_frame_done <= 1'b0;
      if (state == COLLECT) begin
        for (int unsigned n = 0; n < NUM_NEURON; n++) begin
          if (i_data_valid[n]) begin
            buffer[n] <= i_data[n*DATA_WIDTH +: DATA_WIDTH];
          end
        end
        mask <= mask | i_data_valid;
        if (|(mask & i_data_valid)) begin
          o_overflow <= 1'b1;
        end
        if (frame_full) begin
          index <= '0;
        end
      end else begin
        // Strobes arriving while streaming are dropped; the buffer is frozen.
        if (|i_data_valid) begin
          o_overflow <= 1'b1;
        end
        if (ready_all) begin
          o_data       <= buffer[index];
          o_data_valid <= 1'b1;
          if (last_word) begin
            o_frame_done <= 1'b1;
            mask         <= '0;
            index        <= '0;
          end else begin
            index <= index + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: doc/layer_sequencer.md
# layer_sequencer

Inter-layer sequencer between two neuron layers. Captures the NUM_NEURON parallel activations of one layer, which each neuron's valid strobe delivers, into a frame buffer. Once the frame is complete, it streams the activations one word at a time into the shared serial input of the next layer, gated by that layer's per-neuron ready flags. This is the sole path from a layer's concatenated output bus to the next layer's input stream.

## Interface
- NUM_NEURON, 10: neurons in the producing layer; frame length in words.
- NUM_NEXT, 10: neurons in the consuming layer; width of ready vector.
- DATA_WIDTH, 16: activation word width.

Ports:
- i_clk  in  1  sole clock; all state changes on rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_data  in  NUM_NEURON*DATA_WIDTH  producing-layer outputs; lane n = i_data[n*DATA_WIDTH +: DATA_WIDTH].
- i_data_valid  in  NUM_NEURON  per-lane valid strobe; bit n qualifies lane n.
- i_next_ready  in  NUM_NEXT  consuming-layer input-ready flags.
- o_data  out  DATA_WIDTH  serial activation to next layer (drives its i_input).
- o_data_valid  out  1  one-cycle strobe qualifying o_data.
- o_busy  out  1  high while in STREAM.
- o_frame_done  out  1  one-cycle pulse coincident with the last word of a frame.
- o_overflow  out  1  sticky error flag; cleared only by i_reset.

## Operation
- Internal state: buffer of NUM_NEURON words, capture mask of NUM_NEURON bits, index of max($clog2(NUM_NEURON),1) bits, FSM {COLLECT, STREAM}.
- COLLECT:
  - On each edge, every lane n with i_data_valid[n]=1 is written to buffer[n] and mask[n] is set.
  - Lanes may arrive in any order and in any mix of cycles.
  - A strobe on a lane whose mask bit is already set overwrites buffer[n] and sets o_overflow.
  - When (mask | i_data_valid) is all ones at an edge, the FSM moves to STREAM at that edge and index is set to 0.
- STREAM:
  - ready_all = &i_next_ready.
  - At each edge where ready_all=1: o_data <= buffer[index], o_data_valid <= 1, index++.
  - At each edge where ready_all=0: o_data_valid <= 0 and index holds.
  - When the word issued has index=NUM_NEURON-1, at that same edge:
    - o_frame_done <= 1;
    - mask clears to 0;
    - index <= 0;
    - FSM returns to COLLECT.
  - Any i_data_valid bit high during a STREAM cycle sets o_overflow. That lane's data is dropped and the buffer is unchanged.
- o_data holds its last value when o_data_valid=0.
- o_busy = (state==STREAM), decoded from the state register.
- NUM_NEURON=1: the first issued word is also the last, and it carries o_frame_done.

## Timing
- Reset applies at the edge on which i_reset=1 is sampled. It overrides all other activity, including mid-frame.
  - State after reset: COLLECT, mask=0, index=0, buffer=0.
  - Outputs after reset: o_data=0, o_data_valid=0, o_busy=0, o_frame_done=0, o_overflow=0.
- Latency:
  - Frame completes at edge k (STREAM from edge k).
  - If ready_all=1 throughout, word 0 appears valid after edge k+1 and word NUM_NEURON-1 after edge k+NUM_NEURON.
  - Capture-to-first-word latency is 1 cycle.
  - Throughput is one word per cycle.
- Handshake: ready_all is sampled in the cycle before the word is issued. The consuming layer must accept any word that is presented with o_data_valid=1. There is no retraction.
- Ready drops mid-frame: valid gaps are inserted, word order is preserved, and no word is duplicated or skipped.
- Simultaneous events:
  - All lane strobes in one cycle complete the frame in that cycle.
  - On the edge that issues the last word, inputs sampled are still STREAM inputs (overflow).
  - Capture of the next frame begins with the following cycle.
- o_frame_done and o_data_valid are both high for exactly one cycle on the last word.

## Test plan
- Reset, then all 10 lanes strobed together with lane n = 16'h0100+n, ready all ones:
  - o_busy high the next cycle;
  - o_data = 0x0100..0x0109 on 10 consecutive cycles, starting 1 cycle after capture;
  - o_frame_done with 0x0109;
  - o_overflow=0.
- Lanes strobed one per cycle in reverse order (9..0) with values 0xA000+n: no output until lane 0 is captured, then 0xA000..0xA009 in ascending order.
- Frame streaming, i_next_ready[3] cleared for 3 cycles after word 4 issues: exactly 3 valid gaps; words 5..9 follow intact; 10 valid strobes total.
- Lane 2 strobed twice in COLLECT (0x1111 then 0x2222) before the frame completes: word 2 streams as 0x2222 and o_overflow=1 and stays 1.
- Lane 0 strobed during STREAM: o_overflow=1, streamed data unchanged, next frame requires a fresh lane-0 strobe.
- i_reset asserted after word 5 of a frame: the next cycle has all outputs 0 and o_busy=0; a new full frame then streams correctly from word 0.
